// File: rtl/s_poly_eval_pkg.sv
// Shared constants, coefficient slice positions, FSM encoding and saturation helpers
// for the S-segment cubic evaluator.
package s_poly_eval_pkg;

    localparam int unsigned X_W    = 24;
    localparam int unsigned C_W    = 42;
    localparam int unsigned N_COEF = 4;
    localparam int unsigned COF_W  = C_W * N_COEF;

    // c0 sits in the top slice of the ROM word, c3 in the bottom slice
    localparam int unsigned C0_MSB = 167;
    localparam int unsigned C0_LSB = 126;
    localparam int unsigned C1_MSB = 125;
    localparam int unsigned C1_LSB = 84;
    localparam int unsigned C2_MSB = 83;
    localparam int unsigned C2_LSB = 42;
    localparam int unsigned C3_MSB = 41;
    localparam int unsigned C3_LSB = 0;

    localparam logic signed [C_W-1:0] SAT_MAX = {1'b0, {(C_W-1){1'b1}}};
    localparam logic signed [C_W-1:0] SAT_MIN = {1'b1, {(C_W-1){1'b0}}};

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StLoad = 3'd1,
        StMac2 = 3'd2,
        StMac1 = 3'd3,
        StMac0 = 3'd4,
        StDone = 3'd5
    } state_e;

    // Negation whose only overflow case (most negative value) clamps to the maximum
    function automatic logic signed [C_W-1:0] sat_neg(input logic signed [C_W-1:0] a);
        return (a == SAT_MIN) ? SAT_MAX : -a;
    endfunction

endpackage

// File: rtl/s_horner_step.sv
// One Horner step: o_acc = sat(((i_acc * x) >>> X_W) + i_c), x an unsigned Q0.X_W fraction.
module s_horner_step
    import s_poly_eval_pkg::*;
(
    input  logic signed [C_W-1:0] i_acc,
    input  logic        [X_W-1:0] i_x,
    input  logic signed [C_W-1:0] i_c,
    output logic signed [C_W-1:0] o_acc
);

    localparam int unsigned P_W = C_W + X_W + 1;

    logic signed [P_W-1:0] w_acc_ext;
    logic signed [P_W-1:0] w_x_ext;
    logic signed [P_W-1:0] w_prod;
    logic signed [C_W:0]   w_shift;
    logic signed [C_W:0]   w_sum;
    logic                  unused_prod_lo;

    // Full-width signed product; x is zero-extended so it is always non-negative
    assign w_acc_ext = {{(X_W+1){i_acc[C_W-1]}}, i_acc};
    assign w_x_ext   = {{(C_W+1){1'b0}}, i_x};
    assign w_prod    = w_acc_ext * w_x_ext;

    // Dropping the low X_W bits of a two's complement value is a floor toward -inf
    assign w_shift        = w_prod[P_W-1:X_W];
    assign unused_prod_lo = ^w_prod[X_W-1:0];

    assign w_sum = w_shift + {i_c[C_W-1], i_c};

    // Clamp the one-bit-wider sum back into the accumulator range
    always_comb begin
        o_acc = w_sum[C_W-1:0];
        if (w_sum[C_W] != w_sum[C_W-1]) begin
            o_acc = w_sum[C_W] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/s_poly_eval.sv
// Piecewise cubic evaluator: Horner's method over one shared multiply-add step, 6 cycles
// per result. Coefficients arrive from the ROM one cycle after request acceptance.
module s_poly_eval
    import s_poly_eval_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    input  logic        [X_W-1:0] i_x,
    input  logic                  i_neg,
    input  logic      [COF_W-1:0] i_cof,
    output logic                  o_ready,
    output logic                  o_valid,
    output logic signed [C_W-1:0] o_y
);

    state_e                r_state;
    state_e                w_state_next;
    logic        [X_W-1:0] r_x;
    logic                  r_neg;
    logic signed [C_W-1:0] r_c0;
    logic signed [C_W-1:0] r_c1;
    logic signed [C_W-1:0] r_c2;
    logic signed [C_W-1:0] r_acc;
    logic signed [C_W-1:0] r_y;
    logic signed [C_W-1:0] w_coef;
    logic signed [C_W-1:0] w_acc_next;

    // Coefficient fed to the shared step in each MAC state
    always_comb begin
        w_coef = r_c0;
        case (r_state)
            StMac2:  w_coef = r_c2;
            StMac1:  w_coef = r_c1;
            default: w_coef = r_c0;
        endcase
    end

    s_horner_step u_step (
        .i_acc (r_acc),
        .i_x   (r_x),
        .i_c   (w_coef),
        .o_acc (w_acc_next)
    );

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state: fixed sequence once a request is accepted
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (i_valid) w_state_next = StLoad;
            StLoad:  w_state_next = StMac2;
            StMac2:  w_state_next = StMac1;
            StMac1:  w_state_next = StMac0;
            StMac0:  w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Operand, accumulator and result registers; inputs are sampled only in their own state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x   <= '0;
            r_neg <= 1'b0;
            r_c0  <= '0;
            r_c1  <= '0;
            r_c2  <= '0;
            r_acc <= '0;
            r_y   <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_valid) begin
                        r_x   <= i_x;
                        r_neg <= i_neg;
                    end
                end
                StLoad: begin
                    r_c0  <= $signed(i_cof[C0_MSB:C0_LSB]);
                    r_c1  <= $signed(i_cof[C1_MSB:C1_LSB]);
                    r_c2  <= $signed(i_cof[C2_MSB:C2_LSB]);
                    r_acc <= $signed(i_cof[C3_MSB:C3_LSB]);
                end
                StMac2, StMac1: begin
                    r_acc <= w_acc_next;
                end
                StMac0: begin
                    // Result is registered here so it is already on o_y during DONE
                    r_acc <= w_acc_next;
                    r_y   <= r_neg ? sat_neg(w_acc_next) : w_acc_next;
                end
                default: ;
            endcase
        end
    end

    assign o_ready = (r_state == StIdle);
    assign o_valid = (r_state == StDone);
    assign o_y     = r_y;

endmodule

// File: tb/tb_s_poly_eval.sv
// Scoreboard bench for s_poly_eval: stimulus pushes expected results, a monitor pops on o_valid.
module tb_s_poly_eval;
    import s_poly_eval_pkg::*;

    logic               clk   = 1'b0;
    logic               rst_n = 1'b0;
    logic               valid = 1'b0;
    logic               neg   = 1'b0;
    logic [23:0]        x     = '0;
    logic [167:0]       cof   = '0;
    logic               ready;
    logic               ovalid;
    logic signed [41:0] y;

    int n_tests = 0;
    int n_fail  = 0;
    int n_valid = 0;
    int n_push  = 0;
    int cyc     = 0;

    longint q_y[$];
    int     q_acc[$];

    localparam longint M    = 64'sd2199023255551;
    localparam longint MINV = -64'sd2199023255552;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    s_poly_eval dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (valid),
        .i_x     (x),
        .i_neg   (neg),
        .i_cof   (cof),
        .o_ready (ready),
        .o_valid (ovalid),
        .o_y     (y)
    );

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [167:0] mk(input longint c0, input longint c1,
                                        input longint c2, input longint c3);
        logic [63:0] a, b, c, d;
        a = c0; b = c1; c = c2; d = c3;
        return {a[41:0], b[41:0], c[41:0], d[41:0]};
    endfunction

    function automatic logic [167:0] rand_cof();
        logic [191:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return r[167:0];
    endfunction

    // Acceptance log: a request is taken on any cycle where valid and ready are both high
    always @(negedge clk) begin
        if (rst_n && valid && ready) q_acc.push_back(cyc);
    end

    // Monitor: compare each presented result against the scoreboard head
    always @(negedge clk) begin
        if (rst_n && ovalid) begin
            n_valid++;
            if (q_y.size() == 0 || q_acc.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                longint e;
                int     a;
                e = q_y.pop_front();
                a = q_acc.pop_front();
                check("result", y, e);
                check("latency", cyc - a, 5);
            end
        end
    end

    // Single request; entered and left at posedge+1
    task automatic run_one(input logic [167:0] c, input logic [23:0] xv, input logic nv,
                           input longint exp);
        cof = c; x = xv; neg = nv; valid = 1'b1;
        q_y.push_back(exp);
        n_push++;
        @(negedge clk);
        check("ready_idle", ready, 1);
        @(posedge clk); #1;
        valid = 1'b0;
        x     = 24'($urandom);
        neg   = 1'($urandom);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("ready_busy", ready, 0);
            @(posedge clk); #1;
            if (k == 1) cof = rand_cof();
        end
        @(negedge clk);
        check("ready_again", ready, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int acc_cnt;
        int offs[3];

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_valid", ovalid, 0);
        check("rst_y", y, 0);
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;

        run_one(mk(5, 0, 0, 0), 24'h123456, 1'b0, 5);
        run_one(mk(100, 64'sd16777216, 0, 0), 24'h800000, 1'b0, 8388708);
        run_one(mk(100, 64'sd16777216, 0, 0), 24'h800000, 1'b1, -8388708);
        run_one(mk(0, -1, 0, 0), 24'h000001, 1'b0, -1);
        run_one(mk(M, M, M, M), 24'hFFFFFF, 1'b0, M);
        run_one(mk(MINV, 0, 0, 0), 24'h654321, 1'b1, M);
        run_one(mk(0, 0, 0, 64'sd1073741824), 24'h800000, 1'b0, 134217728);
        run_one(mk(13, -11, 7, -3), 24'h400000, 1'b0, 10);

        // Back-pressure: valid held for 13 cycles
        cof = mk(13, -11, 7, -3); x = 24'h400000; neg = 1'b0; valid = 1'b1;
        repeat (3) q_y.push_back(10);
        n_push += 3;
        acc_cnt = 0;
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            if (ready) begin
                if (acc_cnt < 3) offs[acc_cnt] = k;
                acc_cnt++;
            end
            @(posedge clk); #1;
        end
        valid = 1'b0;
        check("bp_count", acc_cnt, 3);
        check("bp_acc0", offs[0], 0);
        check("bp_acc1", offs[1], 6);
        check("bp_acc2", offs[2], 12);
        repeat (6) @(posedge clk);
        #1 cof = rand_cof();

        // Reset during cycle 3 of an evaluation
        cof = mk(13, -11, 7, -3); x = 24'h400000; neg = 1'b0; valid = 1'b1;
        @(posedge clk); #1 valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        check("abort_y", y, 0);
        check("abort_valid", ovalid, 0);
        check("abort_ready", ready, 1);
        @(posedge clk); #2 rst_n = 1'b1;
        q_acc.delete();
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("post_rst_ready", ready, 1);
        @(posedge clk); #1;

        run_one(mk(13, -11, 7, -3), 24'h400000, 1'b1, -10);

        repeat (10) @(posedge clk);
        check("pending", q_y.size(), 0);
        check("valid_count", n_valid, n_push);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
